// File: rtl/window_filter.sv
// 3x3 window filter: bypass, Sobel magnitude, Gaussian blur and Sobel
// threshold over a stream of 3-row columns from an upstream line buffer.
// Fixed 5-cycle latency; sync signals are delayed to match.
module window_filter #(
   parameter int COLORDEPTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [COLORDEPTH-1:0] col_i [2:0],
   input  logic                  dv_i,
   input  logic                  hs_i,
   input  logic                  vs_i,
   input  logic [1:0]            mode_i,
   input  logic [COLORDEPTH-1:0] thr_i,
   output logic [COLORDEPTH-1:0] data_o,
   output logic                  dv_o,
   output logic                  hs_o,
   output logic                  vs_o
);

   localparam int D = COLORDEPTH;

   typedef enum logic [1:0] {
      MODE_BYPASS = 2'd0,
      MODE_SOBEL  = 2'd1,
      MODE_GAUSS  = 2'd2,
      MODE_THRESH = 2'd3
   } mode_t;

   // window columns: w0 newest (right), w1 centre, w2 oldest (left)
   logic [D-1:0]        r_w0 [2:0];
   logic [D-1:0]        r_w1 [2:0];
   logic [D-1:0]        r_w2 [2:0];

   // partial-sum stage
   logic signed [D+2:0] r_gx;
   logic signed [D+2:0] r_gy;
   logic [D+3:0]        r_gsum;
   logic [D-1:0]        r_mid1;

   // abs/normalise stage
   logic [D+3:0]        r_mag;
   logic [D-1:0]        r_gauss;
   logic [D-1:0]        r_mid2;

   // select/saturate stage
   logic [D-1:0]        r_data;

   // sync delay lines and frame-latched controls
   logic [4:0]          r_dv_d;
   logic [4:0]          r_hs_d;
   logic [4:0]          r_vs_d;
   logic                r_vs_prev;
   mode_t               r_mode;
   logic [D-1:0]        r_thr;

   // weighted 1-2-1 sums: column sums (for Gx / Gaussian) and row sums (for Gy)
   logic [D+1:0]        w_cs0, w_cs1, w_cs2;
   logic [D+1:0]        w_rs_bot, w_rs_top;
   logic signed [D+2:0] w_gx, w_gy;
   logic [D+3:0]        w_gsum;
   logic [D+2:0]        w_ax, w_ay;
   logic [D-1:0]        w_sat;
   logic [D-1:0]        w_sel;

   assign w_cs0    = (D+2)'(r_w0[2]) + ((D+2)'(r_w0[1]) << 1) + (D+2)'(r_w0[0]);
   assign w_cs1    = (D+2)'(r_w1[2]) + ((D+2)'(r_w1[1]) << 1) + (D+2)'(r_w1[0]);
   assign w_cs2    = (D+2)'(r_w2[2]) + ((D+2)'(r_w2[1]) << 1) + (D+2)'(r_w2[0]);
   assign w_rs_bot = (D+2)'(r_w2[0]) + ((D+2)'(r_w1[0]) << 1) + (D+2)'(r_w0[0]);
   assign w_rs_top = (D+2)'(r_w2[2]) + ((D+2)'(r_w1[2]) << 1) + (D+2)'(r_w0[2]);
   assign w_gx     = $signed({1'b0, w_cs0}) - $signed({1'b0, w_cs2});
   assign w_gy     = $signed({1'b0, w_rs_bot}) - $signed({1'b0, w_rs_top});
   assign w_gsum   = (D+4)'(w_cs2) + ((D+4)'(w_cs1) << 1) + (D+4)'(w_cs0);

   assign w_ax     = r_gx[D+2] ? unsigned'(-r_gx) : unsigned'(r_gx);
   assign w_ay     = r_gy[D+2] ? unsigned'(-r_gy) : unsigned'(r_gy);

   assign w_sat    = (|r_mag[D+3:D]) ? '1 : r_mag[D-1:0];

   // mode multiplexer applied in the final stage with frame-latched controls
   always_comb begin
      w_sel = '0;
      case (r_mode)
         MODE_BYPASS: w_sel = r_mid2;
         MODE_SOBEL:  w_sel = w_sat;
         MODE_GAUSS:  w_sel = r_gauss;
         MODE_THRESH: w_sel = (w_sat >= r_thr) ? '1 : '0;
         default:     w_sel = '0;
      endcase
   end

   // shift the 3-column window; invalid input columns become zero padding
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_w0 <= '{default: '0};
         r_w1 <= '{default: '0};
         r_w2 <= '{default: '0};
      end else begin
         for (int unsigned i = 0; i < 3; i++) begin
            r_w0[i] <= dv_i ? col_i[i] : '0;
         end
         r_w1 <= r_w0;
         r_w2 <= r_w1;
      end
   end

   // three-stage arithmetic pipeline behind the window
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_gx    <= '0;
         r_gy    <= '0;
         r_gsum  <= '0;
         r_mid1  <= '0;
         r_mag   <= '0;
         r_gauss <= '0;
         r_mid2  <= '0;
         r_data  <= '0;
      end else begin
         r_gx    <= w_gx;
         r_gy    <= w_gy;
         r_gsum  <= w_gsum;
         r_mid1  <= r_w1[1];
         r_mag   <= (D+4)'(w_ax) + (D+4)'(w_ay);
         r_gauss <= r_gsum[D+3:4];
         r_mid2  <= r_mid1;
         r_data  <= r_dv_d[3] ? w_sel : '0;
      end
   end

   // delay sync signals to line up with data_o
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dv_d <= '0;
         r_hs_d <= '0;
         r_vs_d <= '0;
      end else begin
         r_dv_d <= {r_dv_d[3:0], dv_i};
         r_hs_d <= {r_hs_d[3:0], hs_i};
         r_vs_d <= {r_vs_d[3:0], vs_i};
      end
   end

   // latch filter controls only on a vsync rising edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vs_prev <= 1'b0;
         r_mode    <= MODE_BYPASS;
         r_thr     <= '0;
      end else begin
         r_vs_prev <= vs_i;
         if (vs_i && !r_vs_prev) begin
            r_mode <= mode_t'(mode_i);
            r_thr  <= thr_i;
         end
      end
   end

   assign data_o = r_data;
   assign dv_o   = r_dv_d[4];
   assign hs_o   = r_hs_d[4];
   assign vs_o   = r_vs_d[4];

endmodule

// File: doc/window_filter.md
WINDOW_FILTER -- requirements
Module: window_filter

Interface
REQ-001 SHALL have parameter COLORDEPTH, default 8, meaning pixel component width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port col_i  input  3 x COLORDEPTH (unpacked array [2:0])  one image column from the upstream line buffer; [0] newest line (bottom), [1] middle, [2] oldest (top).
REQ-005 SHALL have ports dv_i, hs_i, vs_i  input  1 each  data valid, hsync and vsync, aligned with col_i.
REQ-006 SHALL have port mode_i  input  2  filter select: 0 bypass, 1 Sobel magnitude, 2 Gaussian 3x3, 3 Sobel threshold.
REQ-007 SHALL have port thr_i  input  COLORDEPTH  threshold for mode 3.
REQ-008 SHALL have port data_o  output  COLORDEPTH  filtered pixel.
REQ-009 SHALL have ports dv_o, hs_o, vs_o  output  1 each  the input sync signals delayed to align with data_o.

Function
REQ-010 SHALL hold a 3-column window w0 (newest, spatially right), w1 (centre), w2 (left); each cycle w0 <= dv_i ? col_i : 0, w1 <= w0, w2 <= w1, giving zero horizontal padding at line start and end.
REQ-011 SHALL compute, from the centre column's sample, a fixed latency of 5 cycles to data_o: window (2) + partial sums (1) + abs/normalise (1) + select/saturate (1).
REQ-012 SHALL delay dv_i, hs_i and vs_i by exactly 5 cycles through a shift register.
REQ-013 SHALL drive data_o = 0 whenever dv_o = 0.
REQ-014 Mode 0 SHALL output the w1 middle-row sample unchanged.
REQ-015 Mode 1 SHALL compute Gx = (w0[2]+2w0[1]+w0[0]) - (w2[2]+2w2[1]+w2[0]) and Gy = (w2[0]+2w1[0]+w0[0]) - (w2[2]+2w1[2]+w0[2]) in COLORDEPTH+3-bit signed arithmetic without overflow.
REQ-016 Mode 1 SHALL output |Gx|+|Gy| (COLORDEPTH+4 bits unsigned), saturated to 2^COLORDEPTH-1.
REQ-017 Mode 2 SHALL output the 1-2-1 x 1-2-1 weighted sum (weights total 16, computed in COLORDEPTH+4 bits) shifted right by 4, truncating.
REQ-018 Mode 3 SHALL output all-ones when the saturated mode 1 magnitude >= thr_r, else 0.
REQ-019 SHALL register mode_r and thr_r from mode_i and thr_i only on a vs_i rising edge (vs_i = 1 and its previous-cycle value 0); changes at any other time SHALL have no effect.
REQ-020 SHALL apply mode_r and thr_r in the select/saturate stage; pixels in flight at a vs_i rising edge use the new values (upstream guarantees >= 5 idle dv cycles before a vs_i edge).
REQ-021 SHALL handle back-to-back lines with a single dv_i = 0 cycle correctly; that cycle's zero column pads both lines.
REQ-022 SHALL perform no vertical padding; row content is the upstream line buffer's responsibility.

Reset
REQ-023 On rst = 1, data_o, dv_o, hs_o and vs_o SHALL go to 0 immediately, independent of clk.
REQ-024 Reset SHALL clear all window, pipeline and sync-delay registers to 0, set mode_r = 0 and thr_r = 0, and clear the previous-vs register to 0.
REQ-025 After rst deasserts mid-line, the remainder of that line SHALL be processed as a new line, with the left column zero.

Verification
REQ-026 Reset mid-frame: assert rst with dv_o = 1 and data_o = 0x55 -> all outputs read 0 in the same cycle; after release, mode is bypass.
REQ-027 Bypass: vs_i pulse with mode_i = 0, then an 8-pixel line with col_i[1] = 10,20,...,80 -> data_o = 10,...,80 starting 5 cycles after the first pixel, dv_o high for exactly 8 cycles.
REQ-028 Sobel flat: mode 1, all rows 100 for 8 pixels -> data_o = 255, 0,0,0,0,0,0, 255 (left/right border saturation).
REQ-029 Sobel vertical gradient: mode 1, rows [0]=40, [1]=20, [2]=0, 8 pixels -> interior outputs 160.
REQ-030 Gaussian: mode 2, all rows 100, 8 pixels -> first and last outputs 75, interior outputs 100.
REQ-031 Mode latch: latch mode 3 with thr_i = 100 at vs_i rise, run the REQ-029 gradient line -> interior 255; change mode_i/thr_i mid-frame -> output unchanged until the next vs_i rise.
